// File: rtl/pipe_ctrl_if.sv
// Request/response bundle between the pipeline stages and pipe_ctrl.
// master drives requests; slave is the controller.
interface pipe_ctrl_if #(
  parameter int unsigned STAGES = 6,
  parameter int unsigned HOLD_W = 4,
  parameter int unsigned CNT_W  = 32
);
  logic [STAGES-1:0] stall_req;
  logic              hold_start;
  logic [HOLD_W-1:0] hold_len;
  logic              flush_req;
  logic [STAGES-1:0] stall;
  logic [STAGES-1:0] flush;
  logic              hold_busy;
  logic              stall_timeout;
  logic [CNT_W-1:0]  perf_stall_cyc;
  logic [CNT_W-1:0]  perf_flush_cnt;

  modport master (
    output stall_req, hold_start, hold_len, flush_req,
    input  stall, flush, hold_busy, stall_timeout, perf_stall_cyc, perf_flush_cnt
  );

  modport slave (
    input  stall_req, hold_start, hold_len, flush_req,
    output stall, flush, hold_busy, stall_timeout, perf_stall_cyc, perf_flush_cnt
  );
endinterface

// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush controller with self-timed hold and stall watchdog.
// Define PIPE_CTRL_PERF_EN to build the stall-cycle and flush performance counters.
module pipe_ctrl #(
  parameter int unsigned STAGES      = 6,
  parameter int unsigned HOLD_STAGE  = 3,
  parameter int unsigned FLUSH_STAGE = 4,
  parameter int unsigned HOLD_W      = 4,
  parameter int unsigned WDOG_LIMIT  = 1024,
  parameter int unsigned CNT_W       = 32
) (
  input logic        clk,
  input logic        resetn,
  pipe_ctrl_if.slave bus
);
  localparam int unsigned WCNT_W = $clog2(WDOG_LIMIT + 1);

  typedef enum logic [0:0] {StIdle, StBusy} hold_st_e;

  hold_st_e          state_q, state_d;
  logic [HOLD_W-1:0] cnt_q, cnt_d;
  logic              hold_active;
  logic [STAGES-1:0] stall_raw, flush_raw;
  logic              stall_any;
  logic [WCNT_W-1:0] wcnt_q, wcnt_d;
  logic              timeout_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // The start cycle already counts as one hold cycle, so cnt loads len-1.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    hold_active = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.hold_start && (bus.hold_len != '0) && !bus.flush_req) begin
          hold_active = 1'b1;
          cnt_d       = bus.hold_len - HOLD_W'(1);
          if (cnt_d != '0) state_d = StBusy;
        end
      end
      StBusy: begin
        hold_active = 1'b1;
        cnt_d       = cnt_q - HOLD_W'(1);
        if (cnt_d == '0) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    if (bus.flush_req) begin
      cnt_d   = '0;
      state_d = StIdle;
    end
  end

  // Stage j stalls if any stage at or above j requests: the mask of the highest requester.
  always_comb begin
    stall_raw = '0;
    flush_raw = '0;
    for (int unsigned j = 0; j < STAGES; j++) begin
      stall_raw[j] = |(bus.stall_req >> j);
      if (hold_active && (j <= HOLD_STAGE)) stall_raw[j] = 1'b1;
      if (j <= FLUSH_STAGE) flush_raw[j] = 1'b1;
    end
    if (bus.flush_req) stall_raw = '0;
    else               flush_raw = '0;
  end

  assign bus.stall     = resetn ? stall_raw : '0;
  assign bus.flush     = resetn ? flush_raw : '0;
  assign bus.hold_busy = (cnt_q != '0);
  assign stall_any     = |bus.stall;

  always_comb begin
    wcnt_d = wcnt_q;
    if (!stall_any || bus.flush_req) begin
      wcnt_d = '0;
    end else if (wcnt_q != WCNT_W'(WDOG_LIMIT)) begin
      wcnt_d = wcnt_q + WCNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wcnt_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      wcnt_q    <= wcnt_d;
      timeout_q <= timeout_q | (wcnt_d == WCNT_W'(WDOG_LIMIT));
    end
  end

  assign bus.stall_timeout = timeout_q;

`ifdef PIPE_CTRL_PERF_EN
  logic [CNT_W-1:0] perf_stall_q, perf_flush_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      perf_stall_q <= '0;
      perf_flush_q <= '0;
    end else begin
      if (stall_any)     perf_stall_q <= perf_stall_q + CNT_W'(1);
      if (bus.flush_req) perf_flush_q <= perf_flush_q + CNT_W'(1);
    end
  end

  assign bus.perf_stall_cyc = perf_stall_q;
  assign bus.perf_flush_cnt = perf_flush_q;
`else
  assign bus.perf_stall_cyc = '0;
  assign bus.perf_flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: stall masks, hold, flush, watchdog, perf counters, async reset.
module tb_pipe_ctrl;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  int   total = 0;
  int   bad = 0;

  pipe_ctrl_if #(.STAGES(6), .HOLD_W(4), .CNT_W(32)) bus ();

  pipe_ctrl #(
    .STAGES     (6),
    .HOLD_STAGE (3),
    .FLUSH_STAGE(4),
    .HOLD_W     (4),
    .WDOG_LIMIT (8),
    .CNT_W      (32)
  ) dut (
    .clk   (clk),
    .resetn(resetn),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    resetn = 1'b0;
    bus.stall_req  = '0;
    bus.hold_start = 1'b0;
    bus.hold_len   = '0;
    bus.flush_req  = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    tick();
  endtask

  initial begin
    bus.stall_req  = '0;
    bus.hold_start = 1'b0;
    bus.hold_len   = '0;
    bus.flush_req  = 1'b0;
    #2;
    check("rst_stall", bus.stall, 0);
    check("rst_flush", bus.flush, 0);
    check("rst_busy", bus.hold_busy, 0);
    check("rst_timeout", bus.stall_timeout, 0);
    do_reset();

    // Combinational stall masks
    bus.stall_req = 6'b000100; #1 check("mask_s2", bus.stall, 6'b000111);
    bus.stall_req = 6'b001000; #1 check("mask_s3", bus.stall, 6'b001111);
    bus.stall_req = 6'b001100; #1 check("mask_s23", bus.stall, 6'b001111);
    bus.stall_req = 6'b100000; #1 check("mask_s5", bus.stall, 6'b111111);
    check("mask_noflush", bus.flush, 0);
    bus.stall_req = '0; #1 check("mask_none", bus.stall, 0);
    tick();

    // Hold of 3 cycles; a second start while busy is ignored
    bus.hold_start = 1'b1; bus.hold_len = 4'd3;
    #1 check("hold_c0_stall", bus.stall, 6'b001111);
    check("hold_c0_busy", bus.hold_busy, 0);
    tick();
    bus.hold_start = 1'b0;
    #1 check("hold_c1_stall", bus.stall, 6'b001111);
    check("hold_c1_busy", bus.hold_busy, 1);
    tick();
    bus.hold_start = 1'b1; bus.hold_len = 4'd5;
    #1 check("hold_c2_stall", bus.stall, 6'b001111);
    check("hold_c2_busy", bus.hold_busy, 1);
    tick();
    bus.hold_start = 1'b0;
    #1 check("hold_end_stall", bus.stall, 0);
    check("hold_end_busy", bus.hold_busy, 0);
    bus.hold_start = 1'b1; bus.hold_len = 4'd0;
    #1 check("hold_len0_stall", bus.stall, 0);
    tick();
    bus.hold_start = 1'b0;
    check("hold_len0_busy", bus.hold_busy, 0);
    bus.hold_start = 1'b1; bus.hold_len = 4'd1;
    #1 check("hold_len1_stall", bus.stall, 6'b001111);
    tick();
    bus.hold_start = 1'b0;
    #1 check("hold_len1_after", bus.stall, 0);
    check("hold_len1_busy", bus.hold_busy, 0);
    tick();

    // Flush during a hold with a stage-3 request
    bus.hold_start = 1'b1; bus.hold_len = 4'd4; bus.stall_req = 6'b001000;
    tick();
    bus.hold_start = 1'b0;
    check("fl_busy_before", bus.hold_busy, 1);
    bus.flush_req = 1'b1;
    #1 check("fl_stall", bus.stall, 0);
    check("fl_flush", bus.flush, 6'b011111);
    tick();
    bus.flush_req = 1'b0;
    #1 check("fl_next_busy", bus.hold_busy, 0);
    check("fl_next_stall", bus.stall, 6'b001111);
    check("fl_next_flush", bus.flush, 0);
    // Flush + hold_start + stall_req together: flush only
    bus.flush_req = 1'b1; bus.hold_start = 1'b1; bus.hold_len = 4'd3;
    #1 check("fl_all_stall", bus.stall, 0);
    check("fl_all_flush", bus.flush, 6'b011111);
    tick();
    bus.flush_req = 1'b0; bus.hold_start = 1'b0; bus.stall_req = '0;
    #1 check("fl_all_busy", bus.hold_busy, 0);
    check("fl_all_after", bus.stall, 0);

    // Perf counters: 5 stalled cycles, 2 flush cycles
    do_reset();
    bus.stall_req = 6'b000001;
    repeat (5) tick();
    bus.stall_req = '0; bus.flush_req = 1'b1;
    repeat (2) tick();
    bus.flush_req = 1'b0;
    tick();
`ifdef PIPE_CTRL_PERF_EN
    check("perf_stall", bus.perf_stall_cyc, 5);
    check("perf_flush", bus.perf_flush_cnt, 2);
`else
    check("perf_stall_off", bus.perf_stall_cyc, 0);
    check("perf_flush_off", bus.perf_flush_cnt, 0);
`endif

    // Watchdog: 7-cycle runs separated by gaps never time out
    do_reset();
    bus.stall_req = 6'b000100;
    repeat (7) tick();
    check("wd_run1", bus.stall_timeout, 0);
    bus.stall_req = '0; tick();
    bus.stall_req = 6'b000100;
    repeat (7) tick();
    check("wd_run2", bus.stall_timeout, 0);
    bus.stall_req = '0; tick();
    bus.stall_req = 6'b000100;
    repeat (7) tick();
    check("wd_7th", bus.stall_timeout, 0);
    tick();
    check("wd_8th", bus.stall_timeout, 1);
    bus.stall_req = '0;
    repeat (3) tick();
    check("wd_sticky", bus.stall_timeout, 1);

    // Asynchronous reset in the middle of a hold
    bus.hold_start = 1'b1; bus.hold_len = 4'd3;
    tick();
    bus.hold_start = 1'b0;
    check("ar_busy_pre", bus.hold_busy, 1);
    bus.stall_req = 6'b100000;
    #1 resetn = 1'b0;
    #1 check("ar_stall", bus.stall, 0);
    check("ar_busy", bus.hold_busy, 0);
    check("ar_timeout", bus.stall_timeout, 0);
    check("ar_perf_stall", bus.perf_stall_cyc, 0);
    bus.flush_req = 1'b1;
    #1 check("ar_flush", bus.flush, 0);
    bus.flush_req = 1'b0; bus.stall_req = '0;
    @(negedge clk);
    resetn = 1'b1;
    tick();
    check("ar_post_busy", bus.hold_busy, 0);
    check("ar_post_stall", bus.stall, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
